// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing constants for the fifo and its read-side drain controller.
package fifo_pkg;
    localparam int FIFO_DW    = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_CNT_W = 4;
    localparam int DRAIN_BUF_DEPTH = 3;
    localparam int DRAIN_CNT_W     = 16;
endpackage

// File: rtl/fifo_drain_if.sv
// fifo_drain_if: FIFO read port plus the outgoing valid/ready stream of fifo_drain.
interface fifo_drain_if #(
    parameter int DW    = fifo_pkg::FIFO_DW,
    parameter int CNT_W = fifo_pkg::DRAIN_CNT_W
);
    logic             en;
    logic             fifo_empty;
    logic [DW-1:0]    fifo_data;
    logic             fifo_rd;
    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_data;
    logic [CNT_W-1:0] word_cnt;
    modport master (
        input  en, fifo_empty, fifo_data, m_ready,
        output fifo_rd, m_valid, m_data, word_cnt
    );
    modport slave (
        output en, fifo_empty, fifo_data, m_ready,
        input  fifo_rd, m_valid, m_data, word_cnt
    );
endinterface

// File: rtl/fifo_drain_buf.sv
// fifo_drain_buf: circular word buffer with push/pop, head data and occupancy.
module fifo_drain_buf #(
    parameter int  DW    = 8,
    parameter int  DEPTH = 3,
    localparam int AW    = $clog2(DEPTH),
    localparam int OW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o,
    output logic [OW-1:0] occ_o
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [OW-1:0] occ_q, occ_d;

    // Explicit wrap compare so non-power-of-2 depths work.
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        head_d = pop_i ? inc(head_q) : head_q;
        tail_d = push_i ? inc(tail_q) : tail_q;
        occ_d  = occ_q + OW'(push_i) - OW'(pop_i);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            if (push_i) mem_q[tail_q] <= data_i;
        end
    end

    assign data_o = mem_q[head_q];
    assign occ_o  = occ_q;
endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: pops an external registered-read FIFO into a valid/ready stream.
// Reads are issued only while buffered plus in-flight words leave room in the buffer.
module fifo_drain #(
    parameter int DW        = fifo_pkg::FIFO_DW,
    parameter int BUF_DEPTH = fifo_pkg::DRAIN_BUF_DEPTH,
    parameter int CNT_W     = fifo_pkg::DRAIN_CNT_W
) (
    input logic          clk,
    input logic          rstn,
    fifo_drain_if.master bus
);
    localparam int OW = $clog2(BUF_DEPTH + 1);
    localparam int SW = OW + 1;

    logic             rd_q, pop;
    logic [OW-1:0]    occ;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bus.fifo_rd  = bus.en && !bus.fifo_empty && (SW'(occ) + SW'(rd_q) < SW'(BUF_DEPTH));
    assign bus.m_valid  = occ != '0;
    assign bus.word_cnt = cnt_q;
    assign pop          = bus.m_valid && bus.m_ready;
    assign cnt_d        = cnt_q + CNT_W'(pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            rd_q  <= bus.fifo_rd;
            cnt_q <= cnt_d;
        end
    end

    // The FIFO's data_out is valid the cycle after rd, which is exactly when rd_q is set.
    fifo_drain_buf #(.DW(DW), .DEPTH(BUF_DEPTH)) u_buf (
        .clk    (clk),
        .rstn   (rstn),
        .push_i (rd_q),
        .pop_i  (pop),
        .data_i (bus.fifo_data),
        .data_o (bus.m_data),
        .occ_o  (occ)
    );
endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: drives fifo_drain from a queue-based FIFO and checks it against a word-level model.
module tb_fifo_drain;
    localparam int DW = 8, BD = 3, CW = 4;
    typedef struct { logic [7:0] d; int due; } ent_t;

    logic       clk = 0, rstn = 0, wr = 0;
    logic [7:0] wdata = 0;
    int         total = 0, bad = 0, cyc = 0, ecnt = 0, nrd = 0, got = 0;
    bit         saw;
    logic [CW-1:0] prev;
    logic [7:0] src[$], fq[$];
    ent_t       ob[$];
    int         rd_t[$], v_t[$];
    logic       rd_h[16], v_h[16];
    logic [7:0] d_h[16];

    fifo_drain_if #(.DW(DW), .CNT_W(CW)) bus ();
    fifo_drain #(.DW(DW), .BUF_DEPTH(BD), .CNT_W(CW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 'h%0h expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // External FIFO: registered empty flag, data_out one cycle after rd, reset with the drain.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fq.delete();
            bus.fifo_empty <= 1'b1;
            bus.fifo_data  <= '0;
        end else begin
            if (bus.fifo_rd && fq.size() > 0) bus.fifo_data <= fq.pop_front();
            if (wr) fq.push_back(wdata);
            bus.fifo_empty <= (fq.size() == 0);
        end
    end

    // Word-level model: every word read becomes visible 2 cycles later, in order.
    function automatic bit exp_valid();
        return ob.size() > 0 && ob[0].due <= cyc;
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            ob.delete();
            src.delete();
            ecnt = 0;
        end else begin
            if (exp_valid() && bus.m_ready) begin
                void'(ob.pop_front());
                ecnt++;
            end
            if (bus.fifo_rd) ob.push_back('{d: (src.size() > 0) ? src.pop_front() : 8'h00, due: cyc + 2});
            if (wr) src.push_back(wdata);
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (rstn) begin
            check("fifo_rd", bus.fifo_rd, bus.en && !bus.fifo_empty && ob.size() < BD);
            check("m_valid", bus.m_valid, exp_valid());
            if (exp_valid()) check("m_data", bus.m_data, ob[0].d);
            check("word_cnt", bus.word_cnt, ecnt % (1 << CW));
            check("rd_on_empty", bus.fifo_rd && bus.fifo_empty, 0);
            check("occ_bound", dut.u_buf.occ_q <= BD, 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 0; wr = 0; bus.en = 0; bus.m_ready = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1;
    endtask

    task automatic put(input logic [7:0] d);
        wr = 1; wdata = d;
        step();
        wr = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en = 0; bus.m_ready = 0;
        do_reset();
        #2;
        check("reset_valid", bus.m_valid, 0);
        check("reset_data", bus.m_data, 0);
        check("reset_cnt", bus.word_cnt, 0);
        check("reset_rd", bus.fifo_rd, 0);
        step();

        // Streaming
        for (int i = 0; i < 8; i++) put(8'h11 + 8'(i));
        bus.en = 1; bus.m_ready = 1;
        for (int i = 0; i < 14; i++) begin
            #2;
            rd_h[i] = bus.fifo_rd; v_h[i] = bus.m_valid; d_h[i] = bus.m_data;
            step();
        end
        for (int i = 0; i < 14; i++) begin
            check("stream_rd", rd_h[i], i < 8);
            check("stream_valid", v_h[i], i >= 2 && i < 10);
            if (i >= 2 && i < 10) check("stream_data", d_h[i], 8'h11 + i - 2);
        end
        #2 check("stream_cnt", bus.word_cnt, 8);

        // Backpressure
        do_reset();
        for (int i = 0; i < 8; i++) put(8'hA0 + 8'(i));
        bus.en = 1;
        nrd = 0;
        for (int i = 0; i < 10; i++) begin
            #2 nrd += int'(bus.fifo_rd);
            step();
        end
        check("bp_rd_pulses", nrd, 3);
        #2;
        check("bp_hold_valid", bus.m_valid, 1);
        check("bp_hold_data", bus.m_data, 8'hA0);
        step();
        bus.m_ready = 1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (bus.m_valid) begin
                check("bp_order", bus.m_data, 8'hA0 + got);
                got++;
            end
            step();
        end
        check("bp_count", got, 8);
        #2 check("bp_cnt", bus.word_cnt, 8);

        // Enable gating
        do_reset();
        for (int i = 0; i < 5; i++) put(8'h31 + 8'(i));
        bus.en = 1; bus.m_ready = 1;
        nrd = 0; got = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) bus.en = 0;
            #2;
            nrd += int'(bus.fifo_rd);
            if (bus.m_valid) begin
                check("en_order", bus.m_data, 8'h31 + got);
                got++;
            end
            step();
        end
        check("en_rd_pulses", nrd, 2);
        check("en_delivered", got, 2);
        check("en_fifo_left", fq.size(), 3);
        #2 check("en_idle_valid", bus.m_valid, 0);

        // Sparse input
        do_reset();
        bus.en = 1; bus.m_ready = 1;
        rd_t.delete(); v_t.delete(); got = 0;
        for (int t = 0; t < 34; t++) begin
            wr = (t % 5 == 0) && (t < 30);
            wdata = 8'h50 + 8'(t / 5);
            #2;
            if (bus.fifo_rd) rd_t.push_back(t);
            if (bus.m_valid) begin
                v_t.push_back(t);
                check("sparse_data", bus.m_data, 8'h50 + got);
                got++;
            end
            step();
        end
        wr = 0;
        check("sparse_rd_count", rd_t.size(), 6);
        check("sparse_out_count", v_t.size(), 6);
        for (int k = 0; k < 6 && k < rd_t.size() && k < v_t.size(); k++) begin
            check("sparse_rd_time", rd_t[k], 5 * k + 1);
            check("sparse_latency", v_t[k] - rd_t[k], 2);
        end

        // Counter wrap
        do_reset();
        bus.en = 1; bus.m_ready = 1;
        saw = 0; prev = '0;
        for (int t = 0; t < 40; t++) begin
            wr = t < 17;
            wdata = 8'h70 + 8'(t);
            #2;
            if (prev == 4'd15 && bus.word_cnt == 4'd0) saw = 1;
            prev = bus.word_cnt;
            step();
        end
        wr = 0;
        check("wrap_seen", saw, 1);
        #2 check("wrap_final", bus.word_cnt, 1);
        step();

        // Asynchronous reset mid-stream with two words buffered
        bus.m_ready = 0;
        put(8'h91);
        put(8'h92);
        repeat (6) step();
        #2;
        check("pre_reset_occ", dut.u_buf.occ_q, 2);
        check("pre_reset_data", bus.m_data, 8'h91);
        rstn = 0;
        #1;
        check("async_valid", bus.m_valid, 0);
        check("async_data", bus.m_data, 0);
        check("async_cnt", bus.word_cnt, 0);
        check("async_rd", bus.fifo_rd, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        bus.m_ready = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("post_reset_rd", bus.fifo_rd, 0);
            check("post_reset_valid", bus.m_valid, 0);
            step();
        end
        put(8'hC3);
        #2 check("post_reset_read", bus.fifo_rd, 1);
        step();
        #2 step();
        #2 check("post_reset_word", bus.m_data, 8'hC3);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
